// File: rtl/envm_pkg.sv
// Shared constants for the eNVM pattern store: field codes, test types and
// the written-masks an entry needs before it may be read.
package envm_pkg;

    localparam logic [1:0] FIELD_WEIGHT  = 2'd0;
    localparam logic [1:0] FIELD_ACT     = 2'd1;
    localparam logic [1:0] FIELD_LAUNCH  = 2'd2;
    localparam logic [1:0] FIELD_CAPTURE = 2'd3;

    localparam logic TEST_SA = 1'b0;
    localparam logic TEST_TD = 1'b1;

    localparam logic [2:0] SA_FIELDS_REQ = 3'b111;
    localparam logic [3:0] TD_FIELDS_REQ = 4'b1111;

endpackage

// File: rtl/envm_pattern_bank.sv
// One pattern bank (SA or TD): field arrays, per-entry written-masks and,
// with ENVM_PARITY_EN defined, an even-parity bit per stored word.
module envm_pattern_bank
    import envm_pkg::*;
#(
    parameter int unsigned DEPTH   = 12,
    parameter int unsigned NFIELDS = 3,
    parameter int unsigned AW      = 5,
    parameter int unsigned W_W     = 8,
    parameter int unsigned A_W     = 8,
    parameter int unsigned D_W     = 19,
    parameter logic [NFIELDS-1:0] REQ_MASK = '1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [1:0]     wr_field,
    input  logic [AW-1:0]  wr_addr,
    input  logic [D_W-1:0] wr_data,
    input  logic           wr_par_flip,
    input  logic [AW-1:0]  rd_addr,
    input  logic           rd_ans_sel,
    output logic [W_W-1:0] rd_weight,
    output logic [A_W-1:0] rd_act,
    output logic [D_W-1:0] rd_answer,
    output logic           rd_ok,
    output logic           rd_par_ok
);

    logic [D_W-1:0]     mem  [DEPTH][NFIELDS];
    logic [NFIELDS-1:0] mask [DEPTH];

    logic           wr_ok;
    logic [D_W-1:0] wdata;
    logic           rd_in_range;
    logic [AW-1:0]  rd_idx;
    int unsigned    ans_f;

    assign wr_ok = wr_en && (int'(wr_addr) < DEPTH) && (int'(wr_field) < NFIELDS);

    // Narrow fields are stored zero-extended so parity covers exactly what a read returns.
    always_comb begin
        wdata = wr_data;
        if (wr_field == FIELD_WEIGHT)
            wdata = D_W'(wr_data[W_W-1:0]);
        else if (wr_field == FIELD_ACT)
            wdata = D_W'(wr_data[A_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            mask <= '{default: '0};
        else if (wr_ok)
            mask[wr_addr][wr_field] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr][wr_field] <= wdata;
    end

    assign rd_in_range = int'(rd_addr) < DEPTH;
    assign rd_idx      = rd_in_range ? rd_addr : '0;
    assign ans_f       = (NFIELDS > 3 && rd_ans_sel) ? 3 : 2;

    assign rd_weight = mem[rd_idx][0][W_W-1:0];
    assign rd_act    = mem[rd_idx][1][A_W-1:0];
    assign rd_answer = mem[rd_idx][ans_f];
    assign rd_ok     = rd_in_range && (mask[rd_idx] == REQ_MASK);

`ifdef ENVM_PARITY_EN
    logic par [DEPTH][NFIELDS];

    always_ff @(posedge clk) begin
        if (wr_ok)
            par[wr_addr][wr_field] <= (^wdata) ^ wr_par_flip;
    end

    assign rd_par_ok = ((^mem[rd_idx][0]) == par[rd_idx][0]) &&
                       ((^mem[rd_idx][1]) == par[rd_idx][1]) &&
                       ((^mem[rd_idx][ans_f]) == par[rd_idx][ans_f]);
`else
    logic unused_flip;
    assign unused_flip = wr_par_flip;
    assign rd_par_ok   = 1'b1;
`endif

endmodule

// File: rtl/envm_pattern_store.sv
// eNVM pattern store: SA/TD pattern banks behind a registered read port,
// plus the PE/row/column fault map and its popcount. Option: ENVM_PARITY_EN.
module envm_pattern_store
    import envm_pkg::*;
#(
    parameter int SYSTOLIC_SIZE         = 8,
    parameter int WEIGHT_WIDTH          = 8,
    parameter int ACTIVATION_WIDTH      = 8,
    parameter int PARTIAL_SUM_WIDTH     = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int SA_TEST_PATTERN_DEPTH = 12,
    parameter int TD_TEST_PATTERN_DEPTH = 18,
    parameter int ADDR_WIDTH            = $clog2(SYSTOLIC_SIZE),
    parameter int MAX_ADDR_WIDTH        = $clog2((SA_TEST_PATTERN_DEPTH > TD_TEST_PATTERN_DEPTH) ?
                                                 SA_TEST_PATTERN_DEPTH : TD_TEST_PATTERN_DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  prog_en,
    input  logic                                  prog_type,
    input  logic [1:0]                            prog_field,
    input  logic [MAX_ADDR_WIDTH-1:0]             prog_addr,
    input  logic [PARTIAL_SUM_WIDTH-1:0]          prog_data,
    input  logic                                  inj_parity_flip,
    output logic                                  prog_err,
    input  logic                                  rd_req,
    input  logic                                  test_type,
    input  logic                                  TD_answer_choose,
    input  logic [MAX_ADDR_WIDTH-1:0]             test_counter,
    output logic                                  rd_valid,
    output logic                                  rd_err,
    output logic [WEIGHT_WIDTH-1:0]               Scan_data_weight,
    output logic [ACTIVATION_WIDTH-1:0]           Scan_data_activation,
    output logic [PARTIAL_SUM_WIDTH-1:0]          Scan_data_answer,
    input  logic                                  detection_en,
    input  logic                                  detection_merge,
    input  logic [ADDR_WIDTH-1:0]                 detection_addr,
    input  logic [SYSTOLIC_SIZE-1:0]              single_pe_detection,
    input  logic                                  row_fault_detection,
    input  logic                                  column_fault_detection,
    input  logic                                  clear_faults,
    output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] envm_faulty_patterns_flat,
    output logic [SYSTOLIC_SIZE-1:0]              faulty_row_flat,
    output logic [SYSTOLIC_SIZE-1:0]              faulty_column_flat,
    output logic [$clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)-1:0] fault_count,
    output logic                                  parity_err
);

    localparam int N  = SYSTOLIC_SIZE;
    localparam int CW = $clog2(N*N+1);

    logic                         prog_range_ok, prog_ok;
    logic [WEIGHT_WIDTH-1:0]      sa_w, td_w, sel_w;
    logic [ACTIVATION_WIDTH-1:0]  sa_a, td_a, sel_a;
    logic [PARTIAL_SUM_WIDTH-1:0] sa_ans, td_ans, sel_ans;
    logic                         sa_ok, td_ok, sel_ok;
    logic                         sa_pok, td_pok, sel_pok;
    logic                         rd_fail;

    assign prog_range_ok = (prog_type == TEST_SA) ? (int'(prog_addr) < SA_TEST_PATTERN_DEPTH)
                                                  : (int'(prog_addr) < TD_TEST_PATTERN_DEPTH);
    assign prog_ok = prog_en && prog_range_ok &&
                     !(prog_type == TEST_SA && prog_field == FIELD_CAPTURE);

    envm_pattern_bank #(
        .DEPTH(SA_TEST_PATTERN_DEPTH), .NFIELDS(3), .AW(MAX_ADDR_WIDTH),
        .W_W(WEIGHT_WIDTH), .A_W(ACTIVATION_WIDTH), .D_W(PARTIAL_SUM_WIDTH),
        .REQ_MASK(SA_FIELDS_REQ)
    ) u_sa_bank (
        .clk(clk), .rst_n(rst_n),
        .wr_en(prog_ok && prog_type == TEST_SA), .wr_field(prog_field),
        .wr_addr(prog_addr), .wr_data(prog_data), .wr_par_flip(inj_parity_flip),
        .rd_addr(test_counter), .rd_ans_sel(TD_answer_choose),
        .rd_weight(sa_w), .rd_act(sa_a), .rd_answer(sa_ans),
        .rd_ok(sa_ok), .rd_par_ok(sa_pok)
    );

    envm_pattern_bank #(
        .DEPTH(TD_TEST_PATTERN_DEPTH), .NFIELDS(4), .AW(MAX_ADDR_WIDTH),
        .W_W(WEIGHT_WIDTH), .A_W(ACTIVATION_WIDTH), .D_W(PARTIAL_SUM_WIDTH),
        .REQ_MASK(TD_FIELDS_REQ)
    ) u_td_bank (
        .clk(clk), .rst_n(rst_n),
        .wr_en(prog_ok && prog_type == TEST_TD), .wr_field(prog_field),
        .wr_addr(prog_addr), .wr_data(prog_data), .wr_par_flip(inj_parity_flip),
        .rd_addr(test_counter), .rd_ans_sel(TD_answer_choose),
        .rd_weight(td_w), .rd_act(td_a), .rd_answer(td_ans),
        .rd_ok(td_ok), .rd_par_ok(td_pok)
    );

    assign sel_w   = (test_type == TEST_TD) ? td_w   : sa_w;
    assign sel_a   = (test_type == TEST_TD) ? td_a   : sa_a;
    assign sel_ans = (test_type == TEST_TD) ? td_ans : sa_ans;
    assign sel_ok  = (test_type == TEST_TD) ? td_ok  : sa_ok;
    assign sel_pok = (test_type == TEST_TD) ? td_pok : sa_pok;
    assign rd_fail = !sel_ok || !sel_pok;

    // Banks read combinationally from pre-edge contents, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid             <= 1'b0;
            rd_err               <= 1'b0;
            prog_err             <= 1'b0;
            Scan_data_weight     <= '0;
            Scan_data_activation <= '0;
            Scan_data_answer     <= '0;
        end else begin
            rd_valid <= rd_req;
            rd_err   <= rd_req && rd_fail;
            prog_err <= prog_en && !prog_ok;
            if (rd_req && !rd_fail) begin
                Scan_data_weight     <= sel_w;
                Scan_data_activation <= sel_a;
                Scan_data_answer     <= sel_ans;
            end
        end
    end

`ifdef ENVM_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            parity_err <= 1'b0;
        else if (rd_req && sel_ok && !sel_pok)
            parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif

    logic [N-1:0]  pe_map [N];
    logic [N-1:0]  row_map, col_map;
    logic [CW-1:0] pop;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_faults) begin
            pe_map  <= '{default: '0};
            row_map <= '0;
            col_map <= '0;
        end else if (detection_en && int'(detection_addr) < N) begin
            if (detection_merge) begin
                pe_map[detection_addr]  <= pe_map[detection_addr] | single_pe_detection;
                row_map[detection_addr] <= row_map[detection_addr] | row_fault_detection;
                col_map[detection_addr] <= col_map[detection_addr] | column_fault_detection;
            end else begin
                pe_map[detection_addr]  <= single_pe_detection;
                row_map[detection_addr] <= row_fault_detection;
                col_map[detection_addr] <= column_fault_detection;
            end
        end
    end

    always_comb begin
        pop = '0;
        envm_faulty_patterns_flat = '0;
        for (int unsigned i = 0; i < N; i++) begin
            envm_faulty_patterns_flat[i*N +: N] = pe_map[i];
            for (int unsigned j = 0; j < N; j++)
                pop = pop + CW'(pe_map[i][j]);
        end
    end

    assign faulty_row_flat    = row_map;
    assign faulty_column_flat = col_map;

    always_ff @(posedge clk) begin
        if (!rst_n)
            fault_count <= '0;
        else
            fault_count <= pop;
    end

endmodule

// File: tb/tb_envm_pattern_store.sv
// Scoreboard bench for envm_pattern_store; expected parity behaviour follows ENVM_PARITY_EN.
module tb_envm_pattern_store;

`ifdef ENVM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_en, prog_type, inj_parity_flip, prog_err;
    logic [1:0]  prog_field;
    logic [4:0]  prog_addr;
    logic [18:0] prog_data;
    logic        rd_req, test_type, TD_answer_choose, rd_valid, rd_err;
    logic [4:0]  test_counter;
    logic [7:0]  Scan_data_weight, Scan_data_activation;
    logic [18:0] Scan_data_answer;
    logic        detection_en, detection_merge, row_fault_detection, column_fault_detection, clear_faults;
    logic [2:0]  detection_addr;
    logic [7:0]  single_pe_detection;
    logic [63:0] envm_faulty_patterns_flat;
    logic [7:0]  faulty_row_flat, faulty_column_flat;
    logic [6:0]  fault_count;
    logic        parity_err;

    always #5 clk = ~clk;

    envm_pattern_store dut (
        .clk(clk), .rst_n(rst_n),
        .prog_en(prog_en), .prog_type(prog_type), .prog_field(prog_field),
        .prog_addr(prog_addr), .prog_data(prog_data), .inj_parity_flip(inj_parity_flip),
        .prog_err(prog_err),
        .rd_req(rd_req), .test_type(test_type), .TD_answer_choose(TD_answer_choose),
        .test_counter(test_counter), .rd_valid(rd_valid), .rd_err(rd_err),
        .Scan_data_weight(Scan_data_weight), .Scan_data_activation(Scan_data_activation),
        .Scan_data_answer(Scan_data_answer),
        .detection_en(detection_en), .detection_merge(detection_merge),
        .detection_addr(detection_addr), .single_pe_detection(single_pe_detection),
        .row_fault_detection(row_fault_detection), .column_fault_detection(column_fault_detection),
        .clear_faults(clear_faults),
        .envm_faulty_patterns_flat(envm_faulty_patterns_flat),
        .faulty_row_flat(faulty_row_flat), .faulty_column_flat(faulty_column_flat),
        .fault_count(fault_count), .parity_err(parity_err)
    );

    typedef struct {
        logic        err;
        logic [7:0]  w;
        logic [7:0]  a;
        logic [18:0] ans;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;

    // Reference model of pattern contents, masks, injected-parity flags and fault map.
    logic [18:0] m_data [2][18][4];
    logic [3:0]  m_mask [2][18];
    bit          m_pbad [2][18][4];
    logic [7:0]  last_w = '0, last_a = '0;
    logic [18:0] last_ans = '0;
    logic [63:0] m_pe  = '0;
    logic [7:0]  m_row = '0, m_col = '0;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 with no read outstanding");
            end else begin
                exp_t e;
                e = sb.pop_front();
                pops++;
                if (rd_err !== e.err || Scan_data_weight !== e.w ||
                    Scan_data_activation !== e.a || Scan_data_answer !== e.ans) begin
                    bad++;
                    $display("FAIL read_result: got err=%b w=%h a=%h ans=%h, want err=%b w=%h a=%h ans=%h",
                             rd_err, Scan_data_weight, Scan_data_activation, Scan_data_answer,
                             e.err, e.w, e.a, e.ans);
                end
            end
        end
    end

    task automatic prog(input logic t, input logic [1:0] f, input int a, input logic [18:0] d,
                        input logic flip);
        logic rej;
        rej = (t == 1'b0 && (a >= 12 || f == 2'd3)) || (t == 1'b1 && a >= 18);
        @(negedge clk);
        prog_en = 1'b1; prog_type = t; prog_field = f; prog_addr = 5'(a);
        prog_data = d; inj_parity_flip = flip;
        @(negedge clk);
        prog_en = 1'b0; inj_parity_flip = 1'b0;
        total++;
        if (prog_err !== rej) begin
            bad++;
            $display("FAIL prog_err t=%0d f=%0d a=%0d: got %b want %b", t, f, a, prog_err, rej);
        end
        if (!rej) begin
            m_data[t][a][f] = (f <= 2'd1) ? 19'(d[7:0]) : d;
            m_mask[t][a][f] = 1'b1;
            m_pbad[t][a][f] = flip && PAR_EN;
        end
    endtask

    // Drives a read request for this cycle and queues its expected outcome; caller advances time.
    task automatic issue_read(input logic t, input logic sel, input int idx);
        exp_t e;
        int   af;
        logic [3:0] req;
        req = t ? 4'hF : 4'h7;
        af  = (t && sel) ? 3 : 2;
        rd_req = 1'b1; test_type = t; TD_answer_choose = sel; test_counter = 5'(idx);
        e.err = 1'b1;
        if (idx < (t ? 18 : 12) && m_mask[t][idx] == req) begin
            e.err = m_pbad[t][idx][0] || m_pbad[t][idx][1] || m_pbad[t][idx][af];
            if (!e.err) begin
                last_w   = m_data[t][idx][0][7:0];
                last_a   = m_data[t][idx][1][7:0];
                last_ans = m_data[t][idx][af];
            end
        end
        e.w = last_w; e.a = last_a; e.ans = last_ans;
        sb.push_back(e);
    endtask

    task automatic read1(input logic t, input logic sel, input int idx);
        @(negedge clk);
        issue_read(t, sel, idx);
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 18; i++) m_mask[t][i] = '0;
        last_w = '0; last_a = '0; last_ans = '0;
        m_pe = '0; m_row = '0; m_col = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        total++;
        if (rd_valid !== 1'b0 || rd_err !== 1'b0 || prog_err !== 1'b0 || parity_err !== 1'b0 ||
            Scan_data_weight !== '0 || Scan_data_activation !== '0 || Scan_data_answer !== '0 ||
            envm_faulty_patterns_flat !== '0 || faulty_row_flat !== '0 ||
            faulty_column_flat !== '0 || fault_count !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%b err=%b perr=%b w=%h a=%h ans=%h map=%h cnt=%0d, want all 0",
                     rd_valid, rd_err, prog_err, Scan_data_weight, Scan_data_activation,
                     Scan_data_answer, envm_faulty_patterns_flat, fault_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_program_read();
        prog(1'b0, 2'd0, 3, 19'h12, 1'b0);
        prog(1'b0, 2'd1, 3, 19'h34, 1'b0);
        prog(1'b0, 2'd2, 3, 19'h0ABC, 1'b0);
        read1(1'b0, 1'b0, 3);
        prog(1'b1, 2'd0, 17, 19'h7FF56, 1'b0);
        prog(1'b1, 2'd1, 17, 19'h78, 1'b0);
        read1(1'b1, 1'b0, 17);
        prog(1'b1, 2'd2, 17, 19'h111, 1'b0);
        prog(1'b1, 2'd3, 17, 19'h222, 1'b0);
        read1(1'b1, 1'b0, 17);
        read1(1'b1, 1'b1, 17);
        prog(1'b0, 2'd2, 3, 19'h5A5A5, 1'b0);
        read1(1'b0, 1'b0, 3);
    endtask

    task automatic test_reject();
        prog(1'b0, 2'd0, 12, 19'h99, 1'b0);
        prog(1'b0, 2'd3, 3, 19'h77, 1'b0);
        prog(1'b1, 2'd0, 18, 19'h66, 1'b0);
        read1(1'b0, 1'b0, 15);
        read1(1'b0, 1'b0, 3);
        read1(1'b0, 1'b0, 11);
    endtask

    task automatic detect(input int addr, input logic [7:0] pe, input logic rb, input logic cb,
                          input logic merge, input logic clr);
        @(negedge clk);
        detection_en = 1'b1; detection_addr = 3'(addr); single_pe_detection = pe;
        row_fault_detection = rb; column_fault_detection = cb;
        detection_merge = merge; clear_faults = clr;
        @(negedge clk);
        detection_en = 1'b0; clear_faults = 1'b0;
        if (clr) begin
            m_pe = '0; m_row = '0; m_col = '0;
        end else if (merge) begin
            m_pe[addr*8 +: 8] = m_pe[addr*8 +: 8] | pe;
            m_row[addr] = m_row[addr] | rb;
            m_col[addr] = m_col[addr] | cb;
        end else begin
            m_pe[addr*8 +: 8] = pe;
            m_row[addr] = rb;
            m_col[addr] = cb;
        end
        total++;
        if (envm_faulty_patterns_flat !== m_pe || faulty_row_flat !== m_row ||
            faulty_column_flat !== m_col) begin
            bad++;
            $display("FAIL fault_map addr=%0d: got pe=%h row=%h col=%h, want pe=%h row=%h col=%h",
                     addr, envm_faulty_patterns_flat, faulty_row_flat, faulty_column_flat,
                     m_pe, m_row, m_col);
        end
        @(negedge clk);
        total++;
        if (fault_count !== 7'($countones(m_pe))) begin
            bad++;
            $display("FAIL fault_count: got %0d want %0d", fault_count, $countones(m_pe));
        end
    endtask

    task automatic test_fault_map();
        detect(2, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        detect(2, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
        detect(2, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        detect(7, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0);
        detect(0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        detect(5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_parity();
        prog(1'b0, 2'd0, 5, 19'h5E, 1'b1);
        prog(1'b0, 2'd1, 5, 19'h61, 1'b0);
        prog(1'b0, 2'd2, 5, 19'h0123, 1'b0);
        read1(1'b0, 1'b0, 5);
        total++;
        if (parity_err !== PAR_EN) begin
            bad++;
            $display("FAIL parity_err_set: got %b want %b", parity_err, PAR_EN);
        end
        read1(1'b0, 1'b0, 3);
        total++;
        if (parity_err !== PAR_EN) begin
            bad++;
            $display("FAIL parity_err_sticky: got %b want %b", parity_err, PAR_EN);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        prog(1'b0, 2'd0, 0, 19'h01, 1'b0); prog(1'b0, 2'd1, 0, 19'h02, 1'b0); prog(1'b0, 2'd2, 0, 19'h003, 1'b0);
        prog(1'b0, 2'd0, 1, 19'h11, 1'b0); prog(1'b0, 2'd1, 1, 19'h12, 1'b0); prog(1'b0, 2'd2, 1, 19'h013, 1'b0);
        prog(1'b0, 2'd0, 2, 19'h21, 1'b0); prog(1'b0, 2'd1, 2, 19'h22, 1'b0); prog(1'b0, 2'd2, 2, 19'h023, 1'b0);
        p0 = pops;
        @(negedge clk); issue_read(1'b0, 1'b0, 0);
        @(negedge clk); issue_read(1'b0, 1'b0, 1);
        @(negedge clk); issue_read(1'b0, 1'b0, 2);
        @(negedge clk); rd_req = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (pops - p0 !== 3) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d reads returned, want 3", pops - p0);
        end
        // Reset lands while the second request is being captured: only the first may return.
        @(negedge clk); issue_read(1'b0, 1'b0, 0);
        @(negedge clk);
        rd_req = 1'b1; test_type = 1'b0; test_counter = 5'd1; rst_n = 1'b0;
        @(negedge clk);
        rd_req = 1'b0; rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rd_valid !== 1'b0 || Scan_data_weight !== '0 || Scan_data_activation !== '0 ||
                Scan_data_answer !== '0) begin
                bad++;
                $display("FAIL reset_mid_read cyc=%0d: got valid=%b w=%h a=%h ans=%h, want 0",
                         k, rd_valid, Scan_data_weight, Scan_data_activation, Scan_data_answer);
            end
            @(negedge clk);
        end
        read1(1'b0, 1'b0, 0);
    endtask

    initial begin
        rst_n = 1'b0; prog_en = 1'b0; prog_type = 1'b0; prog_field = '0; prog_addr = '0;
        prog_data = '0; inj_parity_flip = 1'b0; rd_req = 1'b0; test_type = 1'b0;
        TD_answer_choose = 1'b0; test_counter = '0; detection_en = 1'b0; detection_merge = 1'b0;
        detection_addr = '0; single_pe_detection = '0; row_fault_detection = 1'b0;
        column_fault_detection = 1'b0; clear_faults = 1'b0;

        test_reset();
        test_program_read();
        test_reject();
        test_fault_map();
        test_parity();
        test_back_to_back();

        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d reads outstanding, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
